// File: rtl/rca_seg_pg.sv
// -----------------------------------------------------------------------------
// rca_seg_pg
//   NUM_SEG x SEG_W ripple-carry adder with per-segment power gating. Every
//   segment above segment 0 owns a small power sequencer that walks the
//   iso -> ret -> pse handshake on shutdown and reverses it on wake.
//
//   A power request is sampled when the block is idle and differs from the
//   current ON/OFF map. The sampling edge only records the request. Segment
//   FSMs move on the following edge, and all changing segments sequence in
//   parallel. Operands are accepted only while no sequencing is in flight.
//   The sum is registered, so its latency is one cycle.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active-low
//   cin        in   carry into segment 0
//   a, b       in   W-bit operands, W = SEG_W*NUM_SEG
//   in_valid   in   operands valid
//   in_ready   out  operands accepted this cycle (= !pwr_busy)
//   s          out  W+1-bit registered sum, s[W] = carry out of top segment
//   out_valid  out  one-cycle pulse when s is updated
//   pwr_req    in   requested power per segment (bit 0 ignored)
//   pwr_busy   out  a request is launching or any segment is sequencing
//   iso        out  per-segment isolation enable
//   ret        out  per-segment retention hold
//   pse        out  per-segment power switch enable (1 = powered)
//   seg_on     out  segment fully ON
// -----------------------------------------------------------------------------
module rca_seg_pg #(
    parameter int SEG_W     = 16,
    parameter int NUM_SEG   = 4,
    parameter int PWRUP_CYC = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cin,
    input  logic [SEG_W*NUM_SEG-1:0]   a,
    input  logic [SEG_W*NUM_SEG-1:0]   b,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [SEG_W*NUM_SEG:0]     s,
    output logic                       out_valid,
    input  logic [NUM_SEG-1:0]         pwr_req,
    output logic                       pwr_busy,
    output logic [NUM_SEG-1:0]         iso,
    output logic [NUM_SEG-1:0]         ret,
    output logic [NUM_SEG-1:0]         pse,
    output logic [NUM_SEG-1:0]         seg_on
);

    localparam int W     = SEG_W * NUM_SEG;
    localparam int CNT_W = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;

    typedef enum logic [2:0] {
        ST_ON   = 3'd0,
        ST_ISO  = 3'd1,
        ST_SAVE = 3'd2,
        ST_OFF  = 3'd3,
        ST_PUP  = 3'd4,
        ST_REL  = 3'd5
    } seg_state_e;

    seg_state_e             state_q [NUM_SEG];
    seg_state_e             state_d [NUM_SEG];
    logic [CNT_W-1:0]       cnt_q   [NUM_SEG];
    logic [CNT_W-1:0]       cnt_d   [NUM_SEG];

    logic                   start_q;       // request was latched last edge
    logic [NUM_SEG-1:1]     req_q;         // latched target map
    logic [NUM_SEG-1:0]     pwr_req_eff;   // bit 0 forced on
    logic                   launch;
    logic                   seq_active;

    logic [W:0]             sum_d;
    logic [W:0]             s_q;
    logic                   out_valid_q;
    logic [SEG_W:0]         seg_sum;
    logic                   carry;

    // -------------------------------------------------------------------------
    // Power-state decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path through the block leaves a value unassigned (no latch).
        iso        = '0;
        ret        = '0;
        pse        = '0;
        seg_on     = '0;
        seq_active = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            unique case (state_q[i])
                ST_ON:   begin pse[i] = 1'b1; seg_on[i] = 1'b1; end
                ST_ISO:  begin iso[i] = 1'b1; pse[i] = 1'b1; seq_active = 1'b1; end
                ST_SAVE: begin iso[i] = 1'b1; ret[i] = 1'b1; pse[i] = 1'b1;
                               seq_active = 1'b1; end
                ST_OFF:  begin iso[i] = 1'b1; ret[i] = 1'b1; end
                ST_PUP:  begin iso[i] = 1'b1; ret[i] = 1'b1; pse[i] = 1'b1;
                               seq_active = 1'b1; end
                ST_REL:  begin iso[i] = 1'b1; pse[i] = 1'b1; seq_active = 1'b1; end
                default: begin pse[i] = 1'b1; seg_on[i] = 1'b1; end
            endcase
        end
    end

    // The latch edge itself counts as busy, so a new request cannot be
    // sampled before the FSMs have left ON/OFF.
    assign pwr_busy    = start_q | seq_active;
    assign in_ready    = ~pwr_busy;
    assign pwr_req_eff = pwr_req | NUM_SEG'(1);
    assign launch      = ~pwr_busy & (pwr_req_eff != seg_on);

    // -------------------------------------------------------------------------
    // Segment sequencers: next state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_SEG; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        state_d[0] = ST_ON;
        cnt_d[0]   = '0;
        for (int i = 1; i < NUM_SEG; i++) begin
            unique case (state_q[i])
                ST_ON:   if (start_q && !req_q[i]) state_d[i] = ST_ISO;
                ST_ISO:  state_d[i] = ST_SAVE;
                ST_SAVE: state_d[i] = ST_OFF;
                ST_OFF:  if (start_q && req_q[i]) begin
                             state_d[i] = ST_PUP;
                             cnt_d[i]   = CNT_W'(PWRUP_CYC - 1);
                         end
                ST_PUP:  if (cnt_q[i] == '0) state_d[i] = ST_REL;
                         else                cnt_d[i]   = cnt_q[i] - CNT_W'(1);
                ST_REL:  state_d[i] = ST_ON;
                default: state_d[i] = ST_ON;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: each ON segment adds; an isolated segment clamps its sum and
    // its carry out to zero.
    // -------------------------------------------------------------------------
    always_comb begin
        sum_d   = '0;
        carry   = cin;
        seg_sum = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (seg_on[k]) begin
                seg_sum = {1'b0, a[k*SEG_W +: SEG_W]}
                        + {1'b0, b[k*SEG_W +: SEG_W]}
                        + {{SEG_W{1'b0}}, carry};
                sum_d[k*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
                carry                   = seg_sum[SEG_W];
            end else begin
                carry = 1'b0;
            end
        end
        sum_d[W] = carry;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what lets a transfer and a request
    // launch share an edge with the sum still seeing the old power map.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the per-segment state/counter arrays are tiny control
            // registers, not storage, so they are reset like any flop.
            for (int i = 0; i < NUM_SEG; i++) begin
                state_q[i] <= ST_ON;
                cnt_q[i]   <= '0;
            end
            start_q     <= 1'b0;
            req_q       <= '1;
            s_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SEG; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            start_q <= launch;
            if (launch) req_q <= pwr_req_eff[NUM_SEG-1:1];
            out_valid_q <= in_valid & in_ready;
            if (in_valid && in_ready) s_q <= sum_d;
        end
    end

    assign s         = s_q;
    assign out_valid = out_valid_q;

endmodule
